// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the multiply/divide unit.
package muldiv_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } state_e;

    function automatic logic isDiv(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic isSigned(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Turns magnitude results into final HI/LO values, applying the result signs
// and the divide-by-zero / signed-overflow overrides.
module muldiv_sign_fix
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] magHi_i,
    input  logic [WIDTH-1:0] magLo_i,
    input  logic             signA_i,
    input  logic             signB_i,
    input  logic             divZero_i,
    input  logic             ovf_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    // Remainder takes the dividend's sign; quotient and product take the XOR.
    always_comb begin
        hi_o = magHi_i;
        lo_o = magLo_i;
        if (isDiv(op_i)) begin
            if (signA_i ^ signB_i) begin
                lo_o = -magLo_i;
            end
            if (signA_i) begin
                hi_o = -magHi_i;
            end
            if (divZero_i) begin
                lo_o = {WIDTH{1'b1}};
            end
            if (ovf_i) begin
                lo_o = MIN_VAL;
                hi_o = '0;
            end
        end else if (signA_i ^ signB_i) begin
            {hi_o, lo_o} = -{magHi_i, magLo_i};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit holding the HI/LO registers. Defining
// MULDIV_FAST_MULT_EN gives a single-cycle multiply; division stays iterative.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             hi_we_i,
    input  logic             lo_we_i,
    input  logic [WIDTH-1:0] wd_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   magA_q, magA_d;
    logic [WIDTH-1:0]   magB_q, magB_d;
    logic               signA_q, signA_d;
    logic               signB_q, signB_d;
    logic               divZero_q, divZero_d;
    logic               ovf_q, ovf_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               opSigned;
    logic [WIDTH:0]     mulSum;
    logic [WIDTH:0]     divTrial;
    logic [2*WIDTH-1:0] mulNext;
    logic [2*WIDTH-1:0] divNext;
    logic [2*WIDTH-1:0] stepNext;
    logic [WIDTH-1:0]   fixHi;
    logic [WIDTH-1:0]   fixLo;

    assign opSigned = isSigned(op_i);

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    assign mulSum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? magA_q : {WIDTH{1'b0}})};
    assign mulNext = {mulSum, acc_q[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend/quotient bits}, shifted left each step.
    assign divTrial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, magB_q};
    assign divNext  = divTrial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                      : {divTrial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    assign stepNext = isDiv(op_q) ? divNext : mulNext;

`ifdef MULDIV_FAST_MULT_EN
    logic [2*WIDTH-1:0] extA, extB, fastProd;
    assign extA     = {{WIDTH{opSigned & a_i[WIDTH-1]}}, a_i};
    assign extB     = {{WIDTH{opSigned & b_i[WIDTH-1]}}, b_i};
    assign fastProd = extA * extB;
`endif

    muldiv_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .op_i      (op_q),
        .magHi_i   (stepNext[2*WIDTH-1:WIDTH]),
        .magLo_i   (stepNext[WIDTH-1:0]),
        .signA_i   (signA_q),
        .signB_i   (signB_q),
        .divZero_i (divZero_q),
        .ovf_i     (ovf_q),
        .hi_o      (fixHi),
        .lo_o      (fixLo)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        magA_d    = magA_q;
        magB_d    = magB_q;
        signA_d   = signA_q;
        signB_d   = signB_q;
        divZero_d = divZero_q;
        ovf_d     = ovf_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            S_IDLE: begin
                if (hi_we_i) hi_d = wd_i;
                if (lo_we_i) lo_d = wd_i;
                if (start_i) begin
                    op_d      = op_i;
                    signA_d   = opSigned & a_i[WIDTH-1];
                    signB_d   = opSigned & b_i[WIDTH-1];
                    magA_d    = signA_d ? -a_i : a_i;
                    magB_d    = signB_d ? -b_i : b_i;
                    divZero_d = (b_i == '0);
                    ovf_d     = opSigned & isDiv(op_i) & (a_i == MIN_VAL) & (&b_i);
                    cnt_d     = CW'(WIDTH - 1);
                    acc_d     = isDiv(op_i) ? {{WIDTH{1'b0}}, magA_d} : {{WIDTH{1'b0}}, magB_d};
                    state_d   = S_CALC;
`ifdef MULDIV_FAST_MULT_EN
                    if (!isDiv(op_i)) begin
                        {hi_d, lo_d} = fastProd;
                        state_d      = S_DONE;
                    end
`endif
                end
            end
            S_CALC: begin
                acc_d = stepNext;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    cnt_d   = '0;
                    hi_d    = fixHi;
                    lo_d    = fixLo;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            magA_q    <= '0;
            magB_q    <= '0;
            signA_q   <= 1'b0;
            signB_q   <= 1'b0;
            divZero_q <= 1'b0;
            ovf_q     <= 1'b0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            magA_q    <= magA_d;
            magB_q    <= magB_d;
            signA_q   <= signA_d;
            signB_q   <= signB_d;
            divZero_q <= divZero_d;
            ovf_q     <= ovf_d;
            acc_q     <= acc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy_o = (state_q != S_IDLE);
    assign done_o = (state_q == S_DONE);
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit for the single-cycle CPU datapath.
- Consumes the two register-file read outputs as operands and holds the HI/LO result registers.
- Stalls the pipeline through `busy` while it runs.
- HI/LO are read by MFHI/MFLO and written directly by MTHI/MTLO; the CPU routes MFHI/MFLO data back to the register-file write port.

Parameters:
- WIDTH, 32, operand and HI/LO width; the iteration counter is clog2(WIDTH) bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- start_i  input  1  request a new operation; sampled only in IDLE.
- op_i  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a_i  input  WIDTH  operand A (multiplicand/dividend), from register-file read port 0.
- b_i  input  WIDTH  operand B (multiplier/divisor), from register-file read port 1.
- hi_we_i  input  1  MTHI write strobe.
- lo_we_i  input  1  MTLO write strobe.
- wd_i  input  WIDTH  MTHI/MTLO write data.
- busy_o  output  1  high whenever state != IDLE.
- done_o  output  1  one-cycle pulse when HI/LO hold a new result.
- hi_o  output  WIDTH  HI register (product high word / remainder).
- lo_o  output  WIDTH  LO register (product low word / quotient).

Behaviour:
- Clock and reset
  - Single clock: clk.
  - Reset is synchronous and active-low on rst_n.
  - With rst_n=0 at a rising edge: state=IDLE, counter=0, hi_o=0, lo_o=0, done_o=0, busy_o=0, internal accumulators=0.
  - Reset mid-operation abandons the operation; HI/LO are cleared and no done_o pulse is produced.
- State machine: IDLE -> CALC -> DONE -> IDLE.
  - IDLE:
    - On start_i=1: latch op_i, latch the magnitudes of a_i/b_i (two's-complement absolute value when op is signed), record the result signs, set counter=WIDTH-1, go to CALC.
  - CALC:
    - One iteration per cycle.
    - Multiply: shift-add, one multiplier bit per cycle, LSB first, into a 2*WIDTH accumulator.
    - Divide: restoring division, one quotient bit per cycle, MSB first.
    - When counter=0, go to DONE; the final sign correction is written into hi_o/lo_o on that same edge.
  - DONE: done_o=1 for exactly this one cycle; then go to IDLE.
- Latency: start_i sampled at edge E0 -> busy_o high from E0 for WIDTH+1 cycles -> done_o high in the cycle after edge E0+WIDTH -> busy_o low after E0+WIDTH+1. For WIDTH=32: 33 busy cycles.
- start_i is ignored in CALC and DONE. The CPU holds the PC on busy_o; no queuing.
- Result rules
  - MULT/MULTU: {hi,lo} = full 2*WIDTH product, signed or unsigned.
  - DIV/DIVU: lo = quotient (truncated toward zero), hi = remainder (sign follows the dividend).
  - Divide by zero: lo=all ones, hi=a_i. No exception.
  - Signed overflow (DIV with a=-2^(WIDTH-1), b=-1): lo=-2^(WIDTH-1), hi=0.
- MTHI/MTLO writes
  - hi_we_i/lo_we_i take effect at the next edge only in IDLE; they are ignored while busy_o=1.
  - hi_we_i together with start_i in IDLE: the write occurs, then the operation result overwrites it at completion.
  - hi_we_i and lo_we_i together: both registers are written with wd_i.
- Operand stability: a_i/b_i are latched at start, so later changes on the register-file ports do not affect the result.

Optional Feature:
- Macro: MULDIV_FAST_MULT_EN.
- When defined:
  - MULT/MULTU use a single-cycle full-width multiplier operator.
  - IDLE -> DONE directly on start; busy_o is high for 1 cycle and done_o appears the cycle after start.
  - Division is unchanged.
- When undefined: multiply uses the WIDTH-cycle shift-add path with identical timing to division.

Decomposition:
- Shared package muldiv_pkg:
  - Op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU).
  - State encoding (S_IDLE, S_CALC, S_DONE).
  - Default WIDTH constant.
- One natural sub-module: muldiv_sign_fix, combinational.
  - Takes magnitude results plus the recorded signs and op.
  - Produces final hi/lo, including the divide-by-zero and overflow overrides.
- The FSM and iteration datapath stay in muldiv_unit.

Test Plan:
- Reset mid-op: start DIVU a=100 b=7, assert rst_n=0 at cycle 10 -> hi_o=0, lo_o=0, busy_o=0, and no done_o pulse afterwards.
- MULT signed: a=0xFFFFFFFE (-2), b=3 -> after 33 busy cycles, done_o pulse; hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV signed: a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU a=100, b=7 -> lo=14, hi=2.
- Boundaries:
  - DIVU a=0x12345678, b=0 -> lo=0xFFFFFFFF, hi=0x12345678.
  - DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Busy interactions:
  - Second start_i and hi_we_i (wd=0xDEAD) asserted mid-CALC -> ignored; the result matches the first op.
  - MTLO with wd=0x55 in IDLE -> lo_o=0x55 next cycle.
- With MULDIV_FAST_MULT_EN defined: MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done_o the cycle after start; hi=0xFFFFFFFE, lo=0x00000001.
